// File: rtl/tl_traffic_sensor.sv
// Vehicle detector front end: sync + debounce per street, queue counters, Ta/Tb presence.
// Arrival lands DB_CYCLES+1 edges after raw is first sampled; Ta/Tb are combinational from q; no backpressure.

module tl_traffic_sensor_street #(
  parameter int DB_CYCLES     = 3,
  parameter int Q_W           = 4,
  parameter int DEPART_CYCLES = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           raw,
  input  logic [1:0]     light,
  output logic [Q_W-1:0] q,
  output logic           ovf
);

  localparam int DCW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int DTW = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;
  localparam logic [DCW-1:0] DC_MAX = DCW'(DB_CYCLES - 1);
  localparam logic [DTW-1:0] DT_MAX = DTW'(DEPART_CYCLES - 1);
  localparam logic [Q_W-1:0] Q_MAX  = {Q_W{1'b1}};

  logic           sync1;
  logic           sync2;
  logic           db;
  logic [DCW-1:0] dcnt;
  logic [DTW-1:0] dt;
  logic           db_flip;
  logic           arr;
  logic           counting;
  logic           dep;

  always_comb begin
    db_flip  = (sync2 != db) && (dcnt == DC_MAX);
    arr      = db_flip && sync2;
    counting = (light == 2'b00) && (q != '0);
    dep      = counting && (dt == DT_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      db    <= 1'b0;
      dcnt  <= '0;
      dt    <= '0;
      q     <= '0;
      ovf   <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;

      if (sync2 == db) begin
        dcnt <= '0;
      end else if (db_flip) begin
        db   <= sync2;
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + DCW'(1);
      end

      // Timer only runs while green with cars waiting; leaving green discards partial progress.
      if (!counting || dep) begin
        dt <= '0;
      end else begin
        dt <= dt + DTW'(1);
      end

      if (arr && !dep) begin
        if (q == Q_MAX) begin
          ovf <= 1'b1;
        end else begin
          q <= q + Q_W'(1);
        end
      end else if (dep && !arr) begin
        q <= q - Q_W'(1);
      end
    end
  end

endmodule

module tl_traffic_sensor #(
  parameter int DB_CYCLES     = 3,
  parameter int Q_W           = 4,
  parameter int DEPART_CYCLES = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           car_a_raw,
  input  logic           car_b_raw,
  input  logic [1:0]     La,
  input  logic [1:0]     Lb,
  output logic           Ta,
  output logic           Tb,
  output logic [Q_W-1:0] qa,
  output logic [Q_W-1:0] qb,
  output logic           ovf_a,
  output logic           ovf_b
);

  tl_traffic_sensor_street #(
    .DB_CYCLES    (DB_CYCLES),
    .Q_W          (Q_W),
    .DEPART_CYCLES(DEPART_CYCLES)
  ) u_street_a (
    .clk  (clk),
    .reset(reset),
    .raw  (car_a_raw),
    .light(La),
    .q    (qa),
    .ovf  (ovf_a)
  );

  tl_traffic_sensor_street #(
    .DB_CYCLES    (DB_CYCLES),
    .Q_W          (Q_W),
    .DEPART_CYCLES(DEPART_CYCLES)
  ) u_street_b (
    .clk  (clk),
    .reset(reset),
    .raw  (car_b_raw),
    .light(Lb),
    .q    (qb),
    .ovf  (ovf_b)
  );

  assign Ta = (qa != '0);
  assign Tb = (qb != '0);

endmodule

// File: tb/tb_tl_traffic_sensor.sv
// Directed bench for tl_traffic_sensor with default parameters.
module tb_tl_traffic_sensor;

  logic       clk;
  logic       reset;
  logic       car_a_raw;
  logic       car_b_raw;
  logic [1:0] La;
  logic [1:0] Lb;
  logic       Ta;
  logic       Tb;
  logic [3:0] qa;
  logic [3:0] qb;
  logic       ovf_a;
  logic       ovf_b;

  int total = 0;
  int bad   = 0;

  tl_traffic_sensor dut (
    .clk      (clk),
    .reset    (reset),
    .car_a_raw(car_a_raw),
    .car_b_raw(car_b_raw),
    .La       (La),
    .Lb       (Lb),
    .Ta       (Ta),
    .Tb       (Tb),
    .qa       (qa),
    .qb       (qb),
    .ovf_a    (ovf_a),
    .ovf_b    (ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Debounced arrival lands on the 5th edge; 12 edges leaves the release fully settled.
  task automatic add_car(input bit street_b);
    if (street_b) car_b_raw = 1'b1; else car_a_raw = 1'b1;
    repeat (6) tick();
    car_a_raw = 1'b0;
    car_b_raw = 1'b0;
    repeat (6) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; car_a_raw = 1'b0; car_b_raw = 1'b0; La = 2'b10; Lb = 2'b10;
    repeat (2) tick();
    reset = 1'b0;
    total++;
    if ({Ta, Tb, qa, qb, ovf_a, ovf_b} !== 12'd0) begin
      bad++; $display("FAIL reset_outputs: got %b want 0", {Ta, Tb, qa, qb, ovf_a, ovf_b});
    end
  endtask

  task automatic test_arrival();
    car_a_raw = 1'b1;
    repeat (4) tick();
    total++;
    if ({Ta, qa} !== 5'd0) begin
      bad++; $display("FAIL arrival_early: got Ta=%b qa=%0d want 0 0", Ta, qa);
    end
    tick();
    total++;
    if (qa !== 4'd1 || Ta !== 1'b1) begin
      bad++; $display("FAIL arrival_latency: got Ta=%b qa=%0d want 1 1", Ta, qa);
    end
    total++;
    if (qb !== 4'd0 || Tb !== 1'b0) begin
      bad++; $display("FAIL arrival_b_quiet: got Tb=%b qb=%0d want 0 0", Tb, qb);
    end
    tick();
    car_a_raw = 1'b0;
    repeat (6) tick();
    total++;
    if (qa !== 4'd1) begin
      bad++; $display("FAIL arrival_release: got qa=%0d want 1", qa);
    end
  endtask

  task automatic test_glitch();
    int errs;
    errs = 0;
    car_a_raw = 1'b1;
    repeat (2) tick();
    car_a_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (qa !== 4'd1 || Ta !== 1'b1) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL glitch_ignored: got qa=%0d Ta=%b (%0d bad cycles) want 1 1", qa, Ta, errs);
    end
  endtask

  task automatic test_drain();
    logic [3:0] exp_q [6];
    exp_q = '{4'd3, 4'd2, 4'd2, 4'd1, 4'd1, 4'd0};
    add_car(1'b0);
    add_car(1'b0);
    total++;
    if (qa !== 4'd3) begin
      bad++; $display("FAIL drain_fill: got qa=%0d want 3", qa);
    end
    La = 2'b00;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (qa !== exp_q[i]) begin
        bad++; $display("FAIL drain_step%0d: got qa=%0d want %0d", i + 1, qa, exp_q[i]);
      end
    end
    total++;
    if (Ta !== 1'b0 || qb !== 4'd0) begin
      bad++; $display("FAIL drain_empty: got Ta=%b qb=%0d want 0 0", Ta, qb);
    end
    La = 2'b10;
  endtask

  task automatic test_arrive_and_depart();
    add_car(1'b0);
    add_car(1'b0);
    total++;
    if (qa !== 4'd2) begin
      bad++; $display("FAIL coincide_fill: got qa=%0d want 2", qa);
    end
    car_a_raw = 1'b1;
    repeat (3) tick();
    La = 2'b00;
    tick();
    tick();
    total++;
    if (qa !== 4'd2) begin
      bad++; $display("FAIL coincide_edge: got qa=%0d want 2", qa);
    end
    tick();
    car_a_raw = 1'b0;
    total++;
    if (qa !== 4'd2) begin
      bad++; $display("FAIL coincide_after: got qa=%0d want 2", qa);
    end
    tick();
    total++;
    if (qa !== 4'd1) begin
      bad++; $display("FAIL coincide_dec1: got qa=%0d want 1", qa);
    end
    repeat (2) tick();
    total++;
    if (qa !== 4'd0 || Ta !== 1'b0) begin
      bad++; $display("FAIL coincide_dec2: got qa=%0d Ta=%b want 0 0", qa, Ta);
    end
    La = 2'b10;
    repeat (6) tick();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 15; i++) add_car(1'b1);
    total++;
    if (qb !== 4'd15 || ovf_b !== 1'b0) begin
      bad++; $display("FAIL sat_15: got qb=%0d ovf_b=%b want 15 0", qb, ovf_b);
    end
    add_car(1'b1);
    total++;
    if (qb !== 4'd15 || ovf_b !== 1'b1 || ovf_a !== 1'b0) begin
      bad++; $display("FAIL sat_16: got qb=%0d ovf_b=%b ovf_a=%b want 15 1 0", qb, ovf_b, ovf_a);
    end
    total++;
    if (qa !== 4'd0 || Ta !== 1'b0) begin
      bad++; $display("FAIL sat_a_quiet: got qa=%0d Ta=%b want 0 0", qa, Ta);
    end
    Lb = 2'b00;
    repeat (32) tick();
    total++;
    if (qb !== 4'd0 || Tb !== 1'b0 || ovf_b !== 1'b1) begin
      bad++; $display("FAIL sat_drained: got qb=%0d Tb=%b ovf_b=%b want 0 0 1", qb, Tb, ovf_b);
    end
    Lb = 2'b10;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (ovf_b !== 1'b0) begin
      bad++; $display("FAIL sat_reset_ovf: got ovf_b=%b want 0", ovf_b);
    end
  endtask

  task automatic test_reset_mid_timer();
    for (int i = 0; i < 5; i++) add_car(1'b0);
    La = 2'b00;
    tick();
    total++;
    if (qa !== 4'd5) begin
      bad++; $display("FAIL midtimer_fill: got qa=%0d want 5", qa);
    end
    reset = 1'b1;
    tick();
    total++;
    if ({Ta, Tb, qa, qb, ovf_a, ovf_b} !== 12'd0) begin
      bad++; $display("FAIL midtimer_reset: got %b want 0", {Ta, Tb, qa, qb, ovf_a, ovf_b});
    end
    reset = 1'b0;
    repeat (6) tick();
    total++;
    if (qa !== 4'd0 || Ta !== 1'b0) begin
      bad++; $display("FAIL midtimer_after: got qa=%0d Ta=%b want 0 0", qa, Ta);
    end
    La = 2'b10;
  endtask

  task automatic test_held_through_reset();
    reset = 1'b1;
    car_a_raw = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (4) tick();
    total++;
    if (qa !== 4'd0) begin
      bad++; $display("FAIL held_early: got qa=%0d want 0", qa);
    end
    tick();
    total++;
    if (qa !== 4'd1 || Ta !== 1'b1) begin
      bad++; $display("FAIL held_arrival: got qa=%0d Ta=%b want 1 1", qa, Ta);
    end
    car_a_raw = 1'b0;
    repeat (6) tick();
  endtask

  initial begin
    test_reset();
    test_arrival();
    test_glitch();
    test_drain();
    test_arrive_and_depart();
    test_saturation();
    test_reset_mid_timer();
    test_held_through_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
